// File: rtl/zx_sram_arbiter.sv
// Arbiter for the shared video/system SRAM: video, CPU and aux masters get fixed-length
// accesses (ADDR, STROBE x N, LATCH) with registered strobes and a one-cycle ack.
`timescale 1ns/1ps
module zx_sram_arbiter #(
  parameter int ADDR_W        = 19,
  parameter int STROBE_CYCLES = 2,
  parameter int AUX_MAX_WAIT  = 7
) (
  input  logic              clk28,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  input  logic              aux_req,
  input  logic              aux_wr,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [7:0]        aux_wdata,
  output logic              aux_ack,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] va,
  input  logic [7:0]        vd_i,
  output logic [7:0]        vd_o,
  output logic              vd_oe,
  output logic              n_vrd,
  output logic              n_vwr
);
  typedef enum logic [1:0] {IDLE, ADDR, STROBE, LATCH} state_t;
  typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_AUX} own_t;
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } acc_t;

  localparam int            SW       = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [SW-1:0] STB_LAST = SW'(STROBE_CYCLES - 1);
  localparam logic [3:0]    AUX_LIM  = 4'(AUX_MAX_WAIT);

  state_t        state;
  own_t          owner;
  logic          wr_q;
  logic [SW-1:0] stb_cnt;
  logic [3:0]    aux_cnt;

  logic vid_el, cpu_el, aux_el, gnt_vld;
  own_t gnt;
  acc_t gnt_acc;

  // The master finishing its LATCH cycle sits out this decision, so a
  // different requester can follow back-to-back.
  always_comb begin
    vid_el  = vid_req && !(state == LATCH && owner == OWN_VID);
    cpu_el  = cpu_req && !(state == LATCH && owner == OWN_CPU);
    aux_el  = aux_req && !(state == LATCH && owner == OWN_AUX);
    gnt_vld = (state == IDLE || state == LATCH) && (vid_el || cpu_el || aux_el);
    gnt     = OWN_VID;
    if (vid_el)                             gnt = OWN_VID;
    else if (aux_el && aux_cnt == AUX_LIM)  gnt = OWN_AUX;
    else if (cpu_el)                        gnt = OWN_CPU;
    else if (aux_el)                        gnt = OWN_AUX;
    case (gnt)
      OWN_CPU: gnt_acc = {cpu_wr, cpu_addr, cpu_wdata};
      OWN_AUX: gnt_acc = {aux_wr, aux_addr, aux_wdata};
      default: gnt_acc = {1'b0, vid_addr, 8'h00};
    endcase
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= OWN_VID;
      wr_q    <= 1'b0;
      stb_cnt <= '0;
      aux_cnt <= '0;
      va      <= '0;
      vd_o    <= '0;
      vd_oe   <= 1'b0;
      n_vrd   <= 1'b1;
      n_vwr   <= 1'b1;
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      aux_ack <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      aux_ack <= 1'b0;

      // Saturates at the threshold so a run of video grants cannot push
      // the count past the point where aux outranks cpu.
      if (!aux_req)
        aux_cnt <= '0;
      else if (gnt_vld) begin
        if (gnt == OWN_AUX)                 aux_cnt <= '0;
        else if (aux_el && aux_cnt < AUX_LIM) aux_cnt <= aux_cnt + 4'd1;
      end

      case (state)
        IDLE, LATCH: begin
          vd_oe <= 1'b0;
          if (gnt_vld) begin
            state <= ADDR;
            busy  <= 1'b1;
            owner <= gnt;
            wr_q  <= gnt_acc.wr;
            va    <= gnt_acc.addr;
            vd_o  <= gnt_acc.wdata;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ADDR: begin
          state   <= STROBE;
          stb_cnt <= '0;
          n_vrd   <= wr_q;
          n_vwr   <= !wr_q;
          vd_oe   <= wr_q;
        end
        STROBE: begin
          if (stb_cnt == STB_LAST) begin
            state   <= LATCH;
            n_vrd   <= 1'b1;
            n_vwr   <= 1'b1;
            if (!wr_q) rdata <= vd_i;
            vid_ack <= (owner == OWN_VID);
            cpu_ack <= (owner == OWN_CPU);
            aux_ack <= (owner == OWN_AUX);
          end else
            stb_cnt <= stb_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zx_sram_arbiter.sv
// Scoreboard bench for zx_sram_arbiter: per-master expected queues filled at issue,
// checked by a pin/ack monitor against a byte-array SRAM model.
`timescale 1ns/1ps
module tb_zx_sram_arbiter;
  localparam int AW  = 19;
  localparam int SC  = 2;
  localparam int AMW = 3;
  localparam int N   = 40;

  logic          clk28 = 1'b0, rst_n = 1'b0;
  logic          vid_req, vid_ack, cpu_req, cpu_wr, cpu_ack, aux_req, aux_wr, aux_ack;
  logic [AW-1:0] vid_addr, cpu_addr, aux_addr, va;
  logic [7:0]    cpu_wdata, aux_wdata, rdata, vd_i, vd_o;
  logic          busy, vd_oe, n_vrd, n_vwr;

  zx_sram_arbiter #(.ADDR_W(AW), .STROBE_CYCLES(SC), .AUX_MAX_WAIT(AMW)) dut (
    .clk28(clk28), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .aux_req(aux_req), .aux_wr(aux_wr), .aux_addr(aux_addr), .aux_wdata(aux_wdata), .aux_ack(aux_ack),
    .rdata(rdata), .busy(busy), .va(va), .vd_i(vd_i), .vd_o(vd_o), .vd_oe(vd_oe),
    .n_vrd(n_vrd), .n_vwr(n_vwr));

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } txn_t;

  logic [7:0] sram [0:(1<<AW)-1];
  logic [7:0] ref_mem [logic [AW-1:0]];
  txn_t       vq[$], cq[$], aq[$];
  int         ack_log[$];
  int         tests = 0, fails = 0, cyc = 0;
  int         vack_t = 0, cack_t = 0, cpu_acks = 0, run = 0;
  logic       low_q = 1'b0, st_wr = 1'b0;
  logic [AW-1:0] st_addr = '0;

  always #18 clk28 = ~clk28;
  assign vd_i = sram[va];

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] * 8'd37 + 8'd11;
  endfunction

  function automatic logic [AW-1:0] base(input int who);
    return (who == 0) ? 19'h00100 : (who == 1) ? 19'h10000 : 19'h20000;
  endfunction

  // SRAM model: preloaded regions, byte written at every clock edge the write strobe is low.
  initial begin
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 16; i++) sram[base(r) | AW'(i)] = pat(base(r) | AW'(i));
    sram[19'h12345] = 8'hA5;
    forever begin
      @(posedge clk28);
      if (rst_n && !n_vwr && vd_oe) sram[va] = vd_o;
    end
  end

  initial forever begin
    @(posedge clk28);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_txn(input string who, input txn_t t);
    chk({who, "_addr"}, 32'(st_addr), 32'(t.addr));
    chk({who, "_kind"}, 32'(st_wr), 32'(t.wr));
    chk({who, "_strobe_len"}, run, SC);
    if (t.wr) begin
      chk({who, "_vd_oe_hold"}, 32'(vd_oe), 1);
      chk({who, "_vd_o"}, 32'(vd_o), 32'(t.data));
      chk({who, "_sram_data"}, 32'(sram[t.addr]), 32'(t.data));
    end else
      chk({who, "_rdata"}, 32'(rdata), 32'(t.data));
  endtask

  // Monitor: every ack pops the owner's expected transaction.
  initial forever begin
    @(negedge clk28);
    if (!rst_n) low_q = 1'b0;
    else begin
      if (vid_ack || cpu_ack || aux_ack) begin
        chk("one_ack", 32'(vid_ack) + 32'(cpu_ack) + 32'(aux_ack), 1);
        if (vid_ack) begin
          ack_log.push_back(0); vack_t = cyc;
          chk("vid_ack_expected", 32'(vq.size() > 0), 1);
          if (vq.size() > 0) check_txn("vid", vq.pop_front());
        end
        if (cpu_ack) begin
          ack_log.push_back(1); cack_t = cyc; cpu_acks++;
          chk("cpu_ack_expected", 32'(cq.size() > 0), 1);
          if (cq.size() > 0) check_txn("cpu", cq.pop_front());
        end
        if (aux_ack) begin
          ack_log.push_back(2);
          chk("aux_ack_expected", 32'(aq.size() > 0), 1);
          if (aq.size() > 0) check_txn("aux", aq.pop_front());
        end
      end
      if (!n_vrd || !n_vwr) begin
        run     = low_q ? run + 1 : 1;
        st_addr = va;
        st_wr   = !n_vwr;
        low_q   = 1'b1;
      end else
        low_q = 1'b0;
    end
  end

  function automatic txn_t mk(input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
    txn_t t;
    t.wr = wr; t.addr = a;
    if (wr) begin ref_mem[a] = d; t.data = d; end
    else t.data = ref_mem[a];
    return t;
  endfunction

  function automatic txn_t rnd(input int who);
    logic [AW-1:0] a;
    logic wr;
    a  = base(who) | AW'($urandom_range(0, 15));
    wr = (who != 0) && ($urandom_range(0, 1) == 1);
    return mk(wr, a, 8'($urandom));
  endfunction

  task automatic vid_txn(input txn_t t, input bit drop);
    int k = 0;
    vq.push_back(t);
    vid_addr = t.addr; vid_req = 1'b1;
    do begin @(negedge clk28); k++; end while (!vid_ack && k < 300);
    chk("vid_ack_seen", 32'(vid_ack), 1);
    @(posedge clk28); #1;
    if (drop) vid_req = 1'b0;
  endtask

  task automatic cpu_txn(input txn_t t, input bit drop);
    int k = 0;
    cq.push_back(t);
    cpu_addr = t.addr; cpu_wr = t.wr; cpu_wdata = t.wr ? t.data : 8'h00; cpu_req = 1'b1;
    do begin @(negedge clk28); k++; end while (!cpu_ack && k < 300);
    chk("cpu_ack_seen", 32'(cpu_ack), 1);
    @(posedge clk28); #1;
    if (drop) cpu_req = 1'b0;
  endtask

  task automatic aux_txn(input txn_t t, input bit drop);
    int k = 0;
    aq.push_back(t);
    aux_addr = t.addr; aux_wr = t.wr; aux_wdata = t.wr ? t.data : 8'h00; aux_req = 1'b1;
    do begin @(negedge clk28); k++; end while (!aux_ack && k < 300);
    chk("aux_ack_seen", 32'(aux_ack), 1);
    @(posedge clk28); #1;
    if (drop) aux_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, k, g1, g2, g3;
    int exp5 [7] = '{0, 1, 0, 2, 0, 1, 1};
    vid_req = 0; vid_addr = '0;
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 0; aux_wr = 0; aux_addr = '0; aux_wdata = '0;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 16; i++) ref_mem[base(r) | AW'(i)] = pat(base(r) | AW'(i));
    ref_mem[19'h12345] = 8'hA5;

    // Reset state
    repeat (3) @(posedge clk28); #1;
    chk("rst_n_vrd", 32'(n_vrd), 1);  chk("rst_n_vwr", 32'(n_vwr), 1);
    chk("rst_vd_oe", 32'(vd_oe), 0);  chk("rst_acks", 32'({vid_ack, cpu_ack, aux_ack}), 0);
    chk("rst_va", 32'(va), 0);        chk("rst_busy", 32'(busy), 0);
    chk("rst_rdata", 32'(rdata), 0);  chk("rst_vd_o", 32'(vd_o), 0);
    rst_n = 1'b1;
    @(posedge clk28); #1;

    // CPU read timing
    fork
      cpu_txn(mk(1'b0, 19'h12345, 8'h00), 1'b1);
      begin
        @(negedge clk28); chk("rd_c0_busy", 32'(busy), 0);
        @(negedge clk28); chk("rd_c1_va", 32'(va), 'h12345); chk("rd_c1_nvrd", 32'(n_vrd), 1);
                          chk("rd_c1_busy", 32'(busy), 1);
        @(negedge clk28); chk("rd_c2_nvrd", 32'(n_vrd), 0);
        @(negedge clk28); chk("rd_c3_nvrd", 32'(n_vrd), 0);
        @(negedge clk28); chk("rd_c4_ack", 32'(cpu_ack), 1); chk("rd_c4_nvrd", 32'(n_vrd), 1);
        @(negedge clk28); chk("rd_c5_ack", 32'(cpu_ack), 0);
      end
    join
    chk("rd_rdata_a5", 32'(rdata), 'hA5);
    repeat (2) @(posedge clk28); #1;

    // CPU write timing, then read-back
    fork
      cpu_txn(mk(1'b1, 19'h04000, 8'h5A), 1'b1);
      begin
        @(negedge clk28);
        @(negedge clk28); chk("wr_c1_nvwr", 32'(n_vwr), 1); chk("wr_c1_oe", 32'(vd_oe), 0);
        @(negedge clk28); chk("wr_c2_nvwr", 32'(n_vwr), 0); chk("wr_c2_oe", 32'(vd_oe), 1);
        @(negedge clk28); chk("wr_c3_nvwr", 32'(n_vwr), 0); chk("wr_c3_vd_o", 32'(vd_o), 'h5A);
        @(negedge clk28); chk("wr_c4_nvwr", 32'(n_vwr), 1); chk("wr_c4_oe", 32'(vd_oe), 1);
                          chk("wr_c4_ack", 32'(cpu_ack), 1);
        @(negedge clk28); chk("wr_c5_oe", 32'(vd_oe), 0);
      end
    join
    cpu_txn(mk(1'b0, 19'h04000, 8'h00), 1'b1);
    chk("wr_readback", 32'(rdata), 'h5A);
    repeat (2) @(posedge clk28); #1;

    // Video and CPU rise together
    ack_log.delete();
    fork
      vid_txn(rnd(0), 1'b1);
      cpu_txn(rnd(1), 1'b1);
    join
    chk("vc_ack_count", ack_log.size(), 2);
    if (ack_log.size() >= 1) chk("vc_first_is_vid", ack_log[0], 0);
    chk("vc_ack_spacing", cack_t - vack_t, 4);
    repeat (2) @(posedge clk28); #1;

    // Aux anti-starvation with all three masters busy
    ack_log.delete();
    fork
      for (int i = 0; i < 3; i++) vid_txn(rnd(0), i == 2);
      for (int i = 0; i < 3; i++) cpu_txn(rnd(1), i == 2);
      aux_txn(rnd(2), 1'b1);
    join
    chk("starve_ack_count", ack_log.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < ack_log.size()) chk($sformatf("starve_order_%0d", i), ack_log[i], exp5[i]);
    repeat (2) @(posedge clk28); #1;

    // Reset during STROBE of a cpu read
    c0 = cpu_acks;
    fork
      cpu_txn(mk(1'b0, 19'h10005, 8'h00), 1'b1);
      begin
        k = 0;
        while (n_vrd && k < 50) begin @(negedge clk28); k++; end
        chk("abort_strobe_seen", 32'(n_vrd), 0);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_nvrd", 32'(n_vrd), 1); chk("abort_nvwr", 32'(n_vwr), 1);
        chk("abort_busy", 32'(busy), 0);  chk("abort_va", 32'(va), 0);
        chk("abort_ack", 32'(cpu_ack), 0);
        @(negedge clk28);
        chk("abort_ack_in_rst", 32'(cpu_ack), 0);
        #5 rst_n = 1'b1;
      end
    join
    repeat (3) @(posedge clk28); #1;
    chk("abort_single_ack", cpu_acks - c0, 1);

    // Randomized traffic from all three masters
    fork
      for (int i = 0; i < N; i++) begin
        g1 = $urandom_range(0, 2);
        vid_txn(rnd(0), g1 != 0 || i == N - 1);
        if (g1 != 0) begin repeat (g1) @(posedge clk28); #1; end
      end
      for (int i = 0; i < N; i++) begin
        g2 = $urandom_range(0, 2);
        cpu_txn(rnd(1), g2 != 0 || i == N - 1);
        if (g2 != 0) begin repeat (g2) @(posedge clk28); #1; end
      end
      for (int i = 0; i < N; i++) begin
        g3 = $urandom_range(0, 2);
        aux_txn(rnd(2), g3 != 0 || i == N - 1);
        if (g3 != 0) begin repeat (g3) @(posedge clk28); #1; end
      end
    join
    repeat (5) @(posedge clk28); #1;
    chk("vq_drained", vq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    chk("aq_drained", aq.size(), 0);
    chk("idle_at_end", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
